// File: rtl/cohort_config_pkg.sv
// rtl/cohort_config_pkg.sv - shared types and register indices for the Cohort configuration interface
package cohort_config_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_QUIESCE = 2'd1,
        ACK          = 2'd2
    } cfg_resp_state_e;

    localparam int CTRL_IDX        = 0;
    localparam int CTRL_ENABLE_BIT = 0;

    // Register map agreed with the configuration unit.
    localparam int CFG_IDX_CTRL      = CTRL_IDX;
    localparam int CFG_IDX_SRC_BASE  = 1;
    localparam int CFG_IDX_DST_BASE  = 2;
    localparam int CFG_IDX_LENGTH    = 3;
    localparam int CFG_IDX_STRIDE    = 4;
    localparam int CFG_IDX_QUEUE_CFG = 5;
    localparam int CFG_IDX_USER0     = 6;
    localparam int CFG_IDX_USER1     = 7;

endpackage

// File: rtl/cohort_config_responder.sv
// rtl/cohort_config_responder.sv - commits configuration writes, deferring non-CTRL writes until the unit is idle
module cohort_config_responder
    import cohort_config_pkg::*;
#(
    parameter int DATA_W          = 64,
    parameter int NUM_REGS        = 8,
    parameter int ADDR_W          = 4,
    parameter int QUIESCE_TIMEOUT = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cfg_valid_i,
    input  logic [ADDR_W-1:0]                cfg_addr_i,
    input  logic [DATA_W-1:0]                cfg_data_i,
    output logic                             cfg_ack_o,
    output logic                             cfg_err_o,
    input  logic                             unit_busy_i,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  cfg_regs_o,
    output logic                             cfg_update_o,
    output logic [ADDR_W-1:0]                cfg_update_idx_o,
    output logic                             enable_o
);

    localparam int CNT_W = (QUIESCE_TIMEOUT > 1) ? $clog2(QUIESCE_TIMEOUT) : 1;

    cfg_resp_state_e    state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               addr_ok;
    logic               is_ctrl;
    logic               commit;
    logic               timed_out;

    assign addr_ok   = 32'(cfg_addr_i) < NUM_REGS;
    assign is_ctrl   = 32'(cfg_addr_i) == CTRL_IDX;
    assign timed_out = wait_cnt_q == CNT_W'(QUIESCE_TIMEOUT - 1);

    // Address and data are used straight from the bus; the initiator holds them until ack.
    always_comb begin
        commit = 1'b0;
        case (state_q)
            IDLE:         commit = cfg_valid_i && addr_ok && (is_ctrl || !unit_busy_i);
            WAIT_QUIESCE: commit = !unit_busy_i;
            default:      commit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_regs_o <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (32'(cfg_addr_i) == i) begin
                    cfg_regs_o[i] <= cfg_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            wait_cnt_q       <= '0;
            cfg_ack_o        <= 1'b0;
            cfg_err_o        <= 1'b0;
            cfg_update_o     <= 1'b0;
            cfg_update_idx_o <= '0;
        end else begin
            cfg_ack_o    <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_update_o <= 1'b0;
            if (commit) begin
                cfg_update_o     <= 1'b1;
                cfg_update_idx_o <= cfg_addr_i;
            end
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        if (!addr_ok) begin
                            state_q   <= ACK;
                            cfg_ack_o <= 1'b1;
                            cfg_err_o <= 1'b1;
                        end else if (commit) begin
                            state_q   <= ACK;
                            cfg_ack_o <= 1'b1;
                        end else begin
                            state_q    <= WAIT_QUIESCE;
                            wait_cnt_q <= '0;
                        end
                    end
                end
                WAIT_QUIESCE: begin
                    // A busy drop on the final timeout cycle still commits.
                    if (commit) begin
                        state_q   <= ACK;
                        cfg_ack_o <= 1'b1;
                    end else if (timed_out) begin
                        state_q   <= ACK;
                        cfg_ack_o <= 1'b1;
                        cfg_err_o <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign enable_o = cfg_regs_o[CTRL_IDX][CTRL_ENABLE_BIT];

    held_request_stable: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == WAIT_QUIESCE) |->
            (cfg_valid_i && $stable(cfg_addr_i) && $stable(cfg_data_i))
    );

endmodule

// File: tb/tb_cohort_config_responder.sv
// tb/tb_cohort_config_responder.sv - directed vector bench for cohort_config_responder
module tb_cohort_config_responder;

    localparam int DATA_W = 64;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W = 4;
    localparam int QT = 16;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            valid = 1'b0;
    logic [ADDR_W-1:0]               addr = '0;
    logic [DATA_W-1:0]               data = '0;
    logic                            busy = 1'b0;
    logic                            ack;
    logic                            err;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic                            upd;
    logic [ADDR_W-1:0]               upd_idx;
    logic                            enable;

    logic [DATA_W-1:0] model [NUM_REGS];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;
        logic              exp_err;
        logic              exp_upd;
    } vec_t;

    vec_t vecs [7];

    cohort_config_responder #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .QUIESCE_TIMEOUT(QT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cfg_valid_i(valid), .cfg_addr_i(addr),
        .cfg_data_i(data), .cfg_ack_o(ack), .cfg_err_o(err), .unit_busy_i(busy),
        .cfg_regs_o(regs), .cfg_update_o(upd), .cfg_update_idx_o(upd_idx),
        .enable_o(enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("%s regs[%0d]", tag, i), regs[i], model[i]);
        check({tag, " enable"}, 64'(enable), 64'(model[0][0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic b);
        valid = 1'b1;
        addr  = a;
        data  = d;
        busy  = b;
    endtask

    initial begin
        vecs[0] = '{addr: 4'd3,  data: 64'hDEAD_BEEF,            busy: 1'b0, exp_err: 1'b0, exp_upd: 1'b1};
        vecs[1] = '{addr: 4'd0,  data: 64'h1,                    busy: 1'b1, exp_err: 1'b0, exp_upd: 1'b1};
        vecs[2] = '{addr: 4'd9,  data: 64'hFFFF,                 busy: 1'b0, exp_err: 1'b1, exp_upd: 1'b0};
        vecs[3] = '{addr: 4'd7,  data: 64'h0123_4567_89AB_CDEF,  busy: 1'b0, exp_err: 1'b0, exp_upd: 1'b1};
        vecs[4] = '{addr: 4'd0,  data: 64'h0,                    busy: 1'b1, exp_err: 1'b0, exp_upd: 1'b1};
        vecs[5] = '{addr: 4'd15, data: 64'h1234,                 busy: 1'b1, exp_err: 1'b1, exp_upd: 1'b0};
        vecs[6] = '{addr: 4'd5,  data: 64'hA5A5_A5A5_5A5A_5A5A,  busy: 1'b0, exp_err: 1'b0, exp_upd: 1'b1};
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        // Reset state
        @(negedge clk);
        cycle();
        rst = 1'b0;
        check("reset ack", 64'(ack), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset upd", 64'(upd), 64'd0);
        check("reset upd_idx", 64'(upd_idx), 64'd0);
        check_regs("reset");

        // Single-cycle writes from the vector table
        for (int v = 0; v < 7; v++) begin
            present(vecs[v].addr, vecs[v].data, vecs[v].busy);
            cycle();
            if (vecs[v].exp_upd) model[vecs[v].addr] = vecs[v].data;
            check($sformatf("vec%0d ack", v), 64'(ack), 64'd1);
            check($sformatf("vec%0d err", v), 64'(err), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d upd", v), 64'(upd), 64'(vecs[v].exp_upd));
            if (vecs[v].exp_upd)
                check($sformatf("vec%0d upd_idx", v), 64'(upd_idx), 64'(vecs[v].addr));
            check_regs($sformatf("vec%0d", v));
            valid = 1'b0;
            busy = 1'b0;
            cycle();
            check($sformatf("vec%0d ack one cycle", v), 64'(ack), 64'd0);
            check($sformatf("vec%0d upd one cycle", v), 64'(upd), 64'd0);
        end

        // Deferred write: held off while busy, acked one cycle after busy falls
        present(4'd2, 64'h55, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check($sformatf("defer busy ack c%0d", k), 64'(ack), 64'd0);
            check($sformatf("defer busy upd c%0d", k), 64'(upd), 64'd0);
        end
        check("defer regs[2] before", regs[2], model[2]);
        busy = 1'b0;
        cycle();
        model[2] = 64'h55;
        check("defer ack", 64'(ack), 64'd1);
        check("defer err", 64'(err), 64'd0);
        check("defer upd", 64'(upd), 64'd1);
        check("defer upd_idx", 64'(upd_idx), 64'd2);
        check_regs("defer");
        valid = 1'b0;
        cycle();
        check("defer ack one cycle", 64'(ack), 64'd0);

        // Timeout: busy held, err ack exactly QT+1 cycles after sampling
        present(4'd4, 64'h4444, 1'b1);
        for (int k = 1; k <= QT; k++) begin
            cycle();
            check($sformatf("timeout wait ack c%0d", k), 64'(ack), 64'd0);
        end
        cycle();
        check("timeout ack", 64'(ack), 64'd1);
        check("timeout err", 64'(err), 64'd1);
        check("timeout upd", 64'(upd), 64'd0);
        check_regs("timeout");
        valid = 1'b0;
        busy = 1'b0;
        cycle();

        // Busy drops on the very cycle the timeout would expire: commit wins
        present(4'd4, 64'h4444, 1'b1);
        for (int k = 1; k <= QT; k++) begin
            cycle();
            check($sformatf("race wait ack c%0d", k), 64'(ack), 64'd0);
        end
        busy = 1'b0;
        cycle();
        model[4] = 64'h4444;
        check("race ack", 64'(ack), 64'd1);
        check("race err", 64'(err), 64'd0);
        check("race upd", 64'(upd), 64'd1);
        check("race upd_idx", 64'(upd_idx), 64'd4);
        check_regs("race");
        valid = 1'b0;
        cycle();

        // Reset while waiting: request dropped, registers cleared
        present(4'd6, 64'h66, 1'b1);
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b1;
        valid = 1'b0;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        check("rstwait ack", 64'(ack), 64'd0);
        check("rstwait upd", 64'(upd), 64'd0);
        check("rstwait upd_idx", 64'(upd_idx), 64'd0);
        check_regs("rstwait");
        for (int k = 0; k < 20; k++) begin
            cycle();
            check($sformatf("rstwait no ack c%0d", k), 64'(ack), 64'd0);
        end
        present(4'd6, 64'h66, 1'b0);
        cycle();
        model[6] = 64'h66;
        check("reissue ack", 64'(ack), 64'd1);
        check("reissue err", 64'(err), 64'd0);
        check("reissue upd_idx", 64'(upd_idx), 64'd6);
        check_regs("reissue");
        valid = 1'b0;
        cycle();

        // Back-to-back: next request presented right after each ack
        present(4'd1, 64'h1111, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check($sformatf("b2b ack c%0d", k), 64'(ack), 64'(k % 2 == 0));
            if (k == 0) present(4'd2, 64'h2222, 1'b0);
            if (k == 2) present(4'd3, 64'h3333, 1'b0);
            if (k == 4) valid = 1'b0;
        end
        model[1] = 64'h1111;
        model[2] = 64'h2222;
        model[3] = 64'h3333;
        check_regs("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cohort_config_responder.md
# cohort_config_responder

Consumer-side end of the Cohort configuration interface. Sits in each producer/consumer/accelerator unit and accepts register writes from the configuration unit. Each write is held by the initiator until acknowledged. The block commits each write into a local register file, defers writes while the unit is busy, and exposes the committed configuration plus update strobes to the datapath.

## Interface
Parameters:
- DATA_W, 64, width of one configuration register
- NUM_REGS, 8, number of registers; index 0 is CTRL
- ADDR_W, 4, width of cfg_addr_i; must satisfy 2^ADDR_W ≥ NUM_REGS
- QUIESCE_TIMEOUT, 1024, maximum cycles to wait for unit_busy_i to fall

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- cfg_valid_i  in  1  write request; held with addr/data stable until cfg_ack_o
- cfg_addr_i  in  ADDR_W  register index
- cfg_data_i  in  DATA_W  write data
- cfg_ack_o  out  1  one-cycle acknowledge pulse
- cfg_err_o  out  1  valid only with cfg_ack_o; 1 = write dropped
- unit_busy_i  in  1  datapath is mid-operation; non-CTRL writes must wait
- cfg_regs_o  out  NUM_REGS×DATA_W  committed register values
- cfg_update_o  out  1  one-cycle pulse when a register was committed
- cfg_update_idx_o  out  ADDR_W  index of the committed register, valid with cfg_update_o
- enable_o  out  1  CTRL[0]

## Operation
- State machine states are IDLE, WAIT_QUIESCE and ACK.
- **IDLE:**
  - If cfg_valid_i=0, stay in IDLE.
  - If cfg_addr_i ≥ NUM_REGS: no write; go to ACK with err=1.
  - If cfg_addr_i=0 (CTRL): commit immediately regardless of unit_busy_i; go to ACK with err=0.
  - Any other index with unit_busy_i=0: commit immediately; go to ACK with err=0.
  - Any other index with unit_busy_i=1: load the timeout counter with 0 and go to WAIT_QUIESCE.
- **WAIT_QUIESCE:**
  - Each cycle, if unit_busy_i=0: commit the latched request and go to ACK with err=0.
  - Otherwise, if the counter has reached QUIESCE_TIMEOUT-1: no write; go to ACK with err=1.
  - Otherwise, increment the counter.
- **ACK:**
  - cfg_ack_o=1 and cfg_err_o holds the registered error for this cycle only.
  - Always return to IDLE.
  - The initiator may present a new request in the cycle after the ack; the block must not sample cfg_valid_i during ACK.
- **Commit:** cfg_regs_o[idx] ← cfg_data_i at the clock edge. At the same edge cfg_update_o and cfg_update_idx_o are registered, so the strobe is visible in the same cycle as cfg_ack_o.
- **Data capture:** addr and data are taken directly from the inputs at commit time; the initiator guarantees they are stable.
- **Protocol checks (simulation assertions only):**
  - cfg_addr_i and cfg_data_i must not change while cfg_valid_i=1 and the request is unacked.
  - cfg_valid_i must not drop before the ack.
- **Reset (rst_i=1, including mid-transaction):**
  - State returns to IDLE and the counter clears.
  - All cfg_regs_o are 0, so enable_o=0.
  - cfg_ack_o, cfg_err_o, cfg_update_o and cfg_update_idx_o are all 0.
  - An in-flight request is silently discarded; the initiator must reissue after reset.

## Timing
- **Latency, immediate commit:** request sampled in cycle N; registers, ack and update are all visible in cycle N+1.
- **Latency, deferred commit:** if unit_busy_i first samples 0 in cycle M, ack and update are visible in cycle M+1.
- **Timeout:** a request entering WAIT_QUIESCE in cycle N with busy held at 1 gets ack with err=1 in cycle N+QUIESCE_TIMEOUT+1.
- **Throughput:** at most one write per 2 cycles.
- **Simultaneous events:**
  - unit_busy_i falling on the same cycle the timeout expires: the commit wins, err=0.
  - rst_i has priority over everything.
- **Ordering:** cfg_regs_o changes only at a commit edge. enable_o is combinational from cfg_regs_o[0][0], with no extra delay.

## Structure
- **Package cohort_config_pkg:**
  - state enum cfg_resp_state_e {IDLE, WAIT_QUIESCE, ACK}
  - localparam CTRL_IDX=0
  - localparam CTRL_ENABLE_BIT=0
  - register-index constants shared with the configuration unit
- No sub-module. The timeout counter, register file and FSM live inline; the counter width is $clog2(QUIESCE_TIMEOUT).

## Test plan
- **Immediate write:** idle, busy=0, write addr=3, data=0xDEAD_BEEF → in the next cycle ack=1, err=0, update=1, update_idx=3, cfg_regs_o[3]=0xDEADBEEF; ack stays high for exactly 1 cycle.
- **Deferred write:** busy=1, write addr=2, data=0x55; drop busy after 10 cycles → no ack while busy; one cycle after busy falls, ack=1, err=0 and regs[2]=0x55.
- **CTRL bypass:** busy=1, write addr=0, data=0x1 → ack in the next cycle and enable_o=1. Then write 0x0 → enable_o=0.
- **Bad index and timeout:**
  - Write addr=9 (NUM_REGS=8) → ack with err=1, no update pulse, registers unchanged.
  - With QUIESCE_TIMEOUT=16, busy held at 1, write addr=4 → ack with err=1 exactly 17 cycles after the request is sampled; regs[4] unchanged.
- **Reset mid-wait:** while in WAIT_QUIESCE, assert rst_i for 1 cycle → no ack is ever issued, all regs=0, enable_o=0. A reissued write then completes normally.
- **Back-to-back writes:** writes to addr 1, 2, 3, each presented the cycle after the previous ack → acks every 2 cycles and all three values committed.
